line_steering_controller: RTL and testbench

- Downstream consumer of the PulseWidthModulation block's five speed PWM lines (fullSpeedPwm, veerSpeedPwm, hardSpeedPwm, ninetySpeedPwm, ninetyFastSpeedPwm).
- Synchronises and debounces the 3-bit line sensor, runs the steering state machine, and routes one PWM line plus a direction bit to each motor driver.
- Sits between the PWM generator and the H-bridge pins.

---
 rtl/line_steering_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_line_steering_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_steering_controller.sv
// Line-following steering controller: sensor sync/debounce, steering FSM and PWM/direction routing.
// Optional macro SEARCH_ON_LOST_EN: LOST state pivots toward the last turn instead of stopping.
module line_steering_controller #(
    parameter int DEBOUNCE     = 4,
    parameter int PIVOT_CYCLES = 16,
    parameter int LOST_CYCLES  = 32,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sensor,
    input  logic       fullSpeedPwm,
    input  logic       veerSpeedPwm,
    input  logic       hardSpeedPwm,
    input  logic       ninetySpeedPwm,
    input  logic       ninetyFastSpeedPwm,
    output logic       leftPwm,
    output logic       rightPwm,
    output logic       leftDir,
    output logic       rightDir,
    output logic [3:0] state
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] PIVOT_MAX = CNT_W'(PIVOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_MAX  = CNT_W'(LOST_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FWD     = 4'd1,
        ST_VEER_L  = 4'd2,
        ST_VEER_R  = 4'd3,
        ST_HARD_L  = 4'd4,
        ST_HARD_R  = 4'd5,
        ST_PIVOT_L = 4'd6,
        ST_PIVOT_R = 4'd7,
        ST_LOST    = 4'd8
    } state_t;

    logic [2:0]       sync_1_r, sync_2_r, sync_prev_r, stable_r;
    logic [DB_W-1:0]  db_cnt_r, db_cnt_s;
    logic [CNT_W-1:0] piv_cnt_r, piv_cnt_s, lost_cnt_r;
    state_t           state_r, state_s;
    logic             last_turn_r, last_turn_s;
    logic             in_pivot_s;
    logic             l_pwm_s, r_pwm_s, l_dir_s, r_dir_s, l_out_s, r_out_s;
    logic             left_pwm_r, right_pwm_r, left_dir_r, right_dir_r;

    assign in_pivot_s = (state_r == ST_PIVOT_L) || (state_r == ST_PIVOT_R);
    assign state      = state_r;
    assign leftPwm    = left_pwm_r;
    assign rightPwm   = right_pwm_r;
    assign leftDir    = left_dir_r;
    assign rightDir   = right_dir_r;

    // Debounce run counter: restarts on any change of the synced value, saturates at DB_MAX.
    always_comb begin
        db_cnt_s = db_cnt_r;
        if (sync_2_r != sync_prev_r) begin
            db_cnt_s = '0;
        end else if (db_cnt_r != DB_MAX) begin
            db_cnt_s = db_cnt_r + DB_W'(1);
        end else begin
            db_cnt_s = db_cnt_r;
        end
    end

    // Two-flop synchroniser, debounce state, stable sensor and lost-line counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1_r    <= 3'b000;
            sync_2_r    <= 3'b000;
            sync_prev_r <= 3'b000;
            db_cnt_r    <= '0;
            stable_r    <= 3'b000;
            lost_cnt_r  <= '0;
        end else begin
            sync_1_r    <= sensor;
            sync_2_r    <= sync_1_r;
            sync_prev_r <= sync_2_r;
            db_cnt_r    <= db_cnt_s;
            if (db_cnt_s == DB_MAX) begin
                stable_r <= sync_2_r;
            end
            if (stable_r != 3'b000) begin
                lost_cnt_r <= '0;
            end else if (lost_cnt_r != LOST_MAX) begin
                lost_cnt_r <= lost_cnt_r + CNT_W'(1);
            end
        end
    end

    // Steering next-state logic; pivots are held until their minimum time has elapsed.
    always_comb begin
        state_s     = state_r;
        piv_cnt_s   = piv_cnt_r;
        last_turn_s = last_turn_r;
        if (!enable) begin
            state_s = ST_IDLE;
        end else if (in_pivot_s && (piv_cnt_r != PIVOT_MAX)) begin
            piv_cnt_s = piv_cnt_r + CNT_W'(1);
        end else begin
            case (stable_r)
                3'b010: state_s = ST_FWD;
                3'b110: state_s = ST_VEER_L;
                3'b011: state_s = ST_VEER_R;
                3'b100: begin
                    state_s     = ST_HARD_L;
                    last_turn_s = 1'b0;
                end
                3'b001: begin
                    state_s     = ST_HARD_R;
                    last_turn_s = 1'b1;
                end
                3'b111: begin
                    state_s   = last_turn_r ? ST_PIVOT_R : ST_PIVOT_L;
                    piv_cnt_s = '0;
                end
                3'b000: begin
                    if (lost_cnt_r == LOST_MAX) begin
                        state_s = ST_LOST;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: state_s = state_r;
            endcase
        end
    end

    // FSM state, pivot timer and last-turn memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            piv_cnt_r   <= '0;
            last_turn_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            piv_cnt_r   <= piv_cnt_s;
            last_turn_r <= last_turn_s;
        end
    end

    // Motor routing per state, with a one-cycle PWM blank whenever a direction bit flips.
    always_comb begin
        l_pwm_s = 1'b0;
        r_pwm_s = 1'b0;
        l_dir_s = 1'b1;
        r_dir_s = 1'b1;
        case (state_r)
            ST_FWD: begin
                l_pwm_s = fullSpeedPwm;
                r_pwm_s = fullSpeedPwm;
            end
            ST_VEER_L: begin
                l_pwm_s = veerSpeedPwm;
                r_pwm_s = fullSpeedPwm;
            end
            ST_VEER_R: begin
                l_pwm_s = fullSpeedPwm;
                r_pwm_s = veerSpeedPwm;
            end
            ST_HARD_L: begin
                l_pwm_s = hardSpeedPwm;
                r_pwm_s = fullSpeedPwm;
            end
            ST_HARD_R: begin
                l_pwm_s = fullSpeedPwm;
                r_pwm_s = hardSpeedPwm;
            end
            ST_PIVOT_L: begin
                l_pwm_s = ninetySpeedPwm;
                l_dir_s = 1'b0;
                r_pwm_s = ninetyFastSpeedPwm;
            end
            ST_PIVOT_R: begin
                r_pwm_s = ninetySpeedPwm;
                r_dir_s = 1'b0;
                l_pwm_s = ninetyFastSpeedPwm;
            end
`ifdef SEARCH_ON_LOST_EN
            ST_LOST: begin
                if (last_turn_r) begin
                    r_pwm_s = ninetySpeedPwm;
                    r_dir_s = 1'b0;
                    l_pwm_s = ninetyFastSpeedPwm;
                end else begin
                    l_pwm_s = ninetySpeedPwm;
                    l_dir_s = 1'b0;
                    r_pwm_s = ninetyFastSpeedPwm;
                end
            end
`else
            ST_LOST: begin
                l_pwm_s = 1'b0;
                r_pwm_s = 1'b0;
            end
`endif
            default: begin
                l_pwm_s = 1'b0;
                r_pwm_s = 1'b0;
            end
        endcase
        if (l_dir_s != left_dir_r) begin
            l_out_s = 1'b0;
        end else begin
            l_out_s = l_pwm_s;
        end
        if (r_dir_s != right_dir_r) begin
            r_out_s = 1'b0;
        end else begin
            r_out_s = r_pwm_s;
        end
    end

    // Registered H-bridge outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_pwm_r  <= 1'b0;
            right_pwm_r <= 1'b0;
            left_dir_r  <= 1'b1;
            right_dir_r <= 1'b1;
        end else begin
            left_pwm_r  <= l_out_s;
            right_pwm_r <= r_out_s;
            left_dir_r  <= l_dir_s;
            right_dir_r <= r_dir_s;
        end
    end

endmodule

// File: tb/tb_line_steering_controller.sv
// Bench for line_steering_controller: directed table of sensor/enable steps plus random
// stimulus, every cycle compared with a timestamp-based behavioural model.
module tb_line_steering_controller;

    localparam int DEBOUNCE     = 4;
    localparam int PIVOT_CYCLES = 16;
    localparam int LOST_CYCLES  = 32;
    localparam int CNT_W        = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] sensor;
    logic       full_pwm, veer_pwm, hard_pwm, ninety_pwm, fast_pwm;
    logic       left_pwm, right_pwm, left_dir, right_dir;
    logic [3:0] state;

    int vectors     = 0;
    int miscompares = 0;

    line_steering_controller #(
        .DEBOUNCE    (DEBOUNCE),
        .PIVOT_CYCLES(PIVOT_CYCLES),
        .LOST_CYCLES (LOST_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .sensor            (sensor),
        .fullSpeedPwm      (full_pwm),
        .veerSpeedPwm      (veer_pwm),
        .hardSpeedPwm      (hard_pwm),
        .ninetySpeedPwm    (ninety_pwm),
        .ninetyFastSpeedPwm(fast_pwm),
        .leftPwm           (left_pwm),
        .rightPwm          (right_pwm),
        .leftDir           (left_dir),
        .rightDir          (right_dir),
        .state             (state)
    );

    always #5 clk = ~clk;

    // Reference model: edge index, time the stable value went to 000, time of pivot entry.
    int         m_t, m_zs, m_piv, m_state;
    logic       m_lt;
    logic [2:0] m_stable;
    logic       m_lp, m_rp, m_ld, m_rd;
    logic [2:0] sq[$];

    task automatic model_reset();
        m_t = 0; m_zs = 0; m_piv = 0; m_state = 0;
        m_lt = 1'b0; m_stable = 3'b000;
        m_lp = 1'b0; m_rp = 1'b0; m_ld = 1'b1; m_rd = 1'b1;
        sq.delete();
        for (int i = 0; i < DEBOUNCE + 2; i++) sq.push_back(3'b000);
    endtask

    task automatic model_step();
        logic       lp, rp, ld, rd, nlt, run;
        logic [2:0] nst;
        int         side, ns;
        m_t = m_t + 1;
        lp = 1'b0; rp = 1'b0; ld = 1'b1; rd = 1'b1; side = -1;
        case (m_state)
            1: begin lp = full_pwm; rp = full_pwm; end
            2: begin lp = veer_pwm; rp = full_pwm; end
            3: begin lp = full_pwm; rp = veer_pwm; end
            4: begin lp = hard_pwm; rp = full_pwm; end
            5: begin lp = full_pwm; rp = hard_pwm; end
            6: side = 0;
            7: side = 1;
`ifdef SEARCH_ON_LOST_EN
            8: side = m_lt ? 1 : 0;
`endif
            default: ;
        endcase
        if (side == 0) begin lp = ninety_pwm; ld = 1'b0; rp = fast_pwm; end
        if (side == 1) begin rp = ninety_pwm; rd = 1'b0; lp = fast_pwm; end

        ns = m_state; nlt = m_lt;
        if (!enable) ns = 0;
        else if ((m_state == 6 || m_state == 7) && (m_t - 1 - m_piv < PIVOT_CYCLES - 1)) ns = m_state;
        else begin
            case (m_stable)
                3'b010: ns = 1;
                3'b110: ns = 2;
                3'b011: ns = 3;
                3'b100: begin ns = 4; nlt = 1'b0; end
                3'b001: begin ns = 5; nlt = 1'b1; end
                3'b111: begin ns = m_lt ? 7 : 6; m_piv = m_t; end
                3'b000: if (m_t - m_zs >= LOST_CYCLES) ns = 8;
                default: ;
            endcase
        end

        run = 1'b1;
        for (int i = 2; i <= DEBOUNCE; i++) if (sq[i] != sq[1]) run = 1'b0;
        nst = run ? sq[1] : m_stable;
        if (nst == 3'b000 && m_stable != 3'b000) m_zs = m_t;
        sq.push_front(sensor);
        void'(sq.pop_back());

        m_lp = (ld != m_ld) ? 1'b0 : lp;
        m_rp = (rd != m_rd) ? 1'b0 : rp;
        m_ld = ld; m_rd = rd;
        m_state = ns; m_lt = nlt; m_stable = nst;
    endtask

    task automatic compare_model(input string name);
        logic [7:0] got, exp;
        got = {state, left_pwm, right_pwm, left_dir, right_dir};
        exp = {m_state[3:0], m_lp, m_rp, m_ld, m_rd};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s edge=%0d {state,lp,rp,ld,rd} got=%h required=%h", name, m_t, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic tick();
        full_pwm   = 1'($urandom_range(0, 1));
        veer_pwm   = 1'($urandom_range(0, 1));
        hard_pwm   = 1'($urandom_range(0, 1));
        ninety_pwm = 1'($urandom_range(0, 1));
        fast_pwm   = 1'($urandom_range(0, 1));
        if (rst) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        compare_model("model");
    endtask

    task automatic async_reset_pulse();
        rst = 1'b0;
        #1;
        model_reset();
        compare_model("async_reset");
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [2:0] sensor;
        logic       enable;
        int         cycles;
        logic [3:0] exp_state;
    } vec_t;

    vec_t tbl [0:23];
    int   len;
    int   r;

    initial begin
        tbl[0]  = '{3'b010, 1'b1,  6, 4'd0};
        tbl[1]  = '{3'b010, 1'b1,  1, 4'd1};
        tbl[2]  = '{3'b110, 1'b1,  3, 4'd1};
        tbl[3]  = '{3'b010, 1'b1,  8, 4'd1};
        tbl[4]  = '{3'b110, 1'b1,  6, 4'd1};
        tbl[5]  = '{3'b110, 1'b1,  1, 4'd2};
        tbl[6]  = '{3'b100, 1'b1,  6, 4'd2};
        tbl[7]  = '{3'b100, 1'b1,  1, 4'd4};
        tbl[8]  = '{3'b111, 1'b1,  6, 4'd4};
        tbl[9]  = '{3'b111, 1'b1,  1, 4'd6};
        tbl[10] = '{3'b111, 1'b1,  5, 4'd6};
        tbl[11] = '{3'b010, 1'b1, 10, 4'd6};
        tbl[12] = '{3'b010, 1'b1,  1, 4'd1};
        tbl[13] = '{3'b000, 1'b1, 37, 4'd1};
        tbl[14] = '{3'b000, 1'b1,  1, 4'd8};
        tbl[15] = '{3'b010, 1'b1,  6, 4'd8};
        tbl[16] = '{3'b010, 1'b1,  1, 4'd1};
        tbl[17] = '{3'b001, 1'b1,  6, 4'd1};
        tbl[18] = '{3'b001, 1'b1,  1, 4'd5};
        tbl[19] = '{3'b001, 1'b0,  1, 4'd0};
        tbl[20] = '{3'b001, 1'b0,  1, 4'd0};
        tbl[21] = '{3'b001, 1'b1,  1, 4'd5};
        tbl[22] = '{3'b111, 1'b1,  6, 4'd5};
        tbl[23] = '{3'b111, 1'b1,  1, 4'd7};

        rst = 1'b0; enable = 1'b1; sensor = 3'b010;
        full_pwm = 1'b0; veer_pwm = 1'b0; hard_pwm = 1'b0; ninety_pwm = 1'b0; fast_pwm = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_model("reset_state");
        tick();
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            sensor = tbl[i].sensor;
            enable = tbl[i].enable;
            for (int k = 0; k < tbl[i].cycles; k++) tick();
            vectors++;
            if (state !== tbl[i].exp_state) begin
                miscompares++;
                $display("FAIL table[%0d] state got=%0d required=%0d", i, state, tbl[i].exp_state);
            end
        end

        // First cycle of PIVOT_R: right motor reverses, so its PWM is blanked.
        tick();
        check_bit("pivot_r_dir", right_dir, 1'b0);
        check_bit("pivot_r_blank", right_pwm, 1'b0);
        for (int k = 0; k < 3; k++) tick();

        // Reset in the middle of the pivot clears everything at once.
        rst = 1'b0;
        #1;
        check_bit("mid_pivot_rst_lpwm", left_pwm, 1'b0);
        check_bit("mid_pivot_rst_rpwm", right_pwm, 1'b0);
        check_bit("mid_pivot_rst_ldir", left_dir, 1'b1);
        check_bit("mid_pivot_rst_rdir", right_dir, 1'b1);
        vectors++;
        if (state !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_pivot_rst_state got=%0d required=0", state);
        end
        model_reset();
        tick();
        rst = 1'b1;

        for (int n = 0; n < 160; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) async_reset_pulse();
            if ($urandom_range(0, 3) == 0) sensor = 3'b000;
            else sensor = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 19) != 0);
            len = (sensor == 3'b000) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 14));
            for (int k = 0; k < len; k++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
